router_bringup_sched: RTL and testbench

ROUTER_BRINGUP_SCHED -- requirements
Module: router_bringup_sched

---
 rtl/router_bringup_sched.sv | 128 ++++++++++++
 tb/tb_router_bringup_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/router_bringup_sched.sv
// router_bringup_sched: router reset bring-up sequencer plus two-requester round-robin transfer scheduler
// Ports: init_clk/sys_reset clock and sync active-high reset; req_valid/req_dst_addr/req_scr_addr
// requests (10-bit addresses packed per requester); req_grant/req_done per-requester pulses;
// router_done async completion from the router; pma_init/reset_pb router resets; router_start_req,
// router_dst_addr/router_scr_addr to the router; link_ready; timeout_err.
// Optional ISSUE timeout enabled by defining ROUTER_TIMEOUT_EN.
module router_bringup_sched #(
  parameter int unsigned PMA_HOLD_CYC = 150,
  parameter int unsigned RST_HOLD_CYC = 250,
  parameter int unsigned SETTLE_CYC   = 1000,
  parameter int unsigned TIMEOUT_CYC  = 100000
) (
  input  logic        init_clk,
  input  logic        sys_reset,
  input  logic [1:0]  req_valid,
  input  logic [19:0] req_dst_addr,
  input  logic [19:0] req_scr_addr,
  output logic [1:0]  req_grant,
  output logic [1:0]  req_done,
  input  logic        router_done,
  output logic        pma_init,
  output logic        reset_pb,
  output logic        router_start_req,
  output logic [9:0]  router_dst_addr,
  output logic [9:0]  router_scr_addr,
  output logic        link_ready,
  output logic        timeout_err
);
  typedef enum logic [2:0] {PMA_HOLD, RST_HOLD, SETTLE, IDLE, ISSUE, COMPLETE} state_t;
  // A zero count still occupies its state for one cycle.
  function automatic logic [31:0] ld(input int unsigned n);
    return (n == 0) ? 32'd1 : n;
  endfunction
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic sync_q, done_s_q;
  logic last_q, last_d, cur_q, cur_d;
  logic [1:0] grant_q, grant_d;
  logic [9:0] dst_q, dst_d, scr_q, scr_d;
  logic expired, sel;
  assign expired = cnt_q <= 32'd1;
  // Requester 0 wins unless requester 1 is also asking and 0 was served last.
  assign sel = !(req_valid[0] && (last_q || !req_valid[1]));
  always_ff @(posedge init_clk) begin
    if (sys_reset) begin
      state_q  <= PMA_HOLD;
      cnt_q    <= ld(PMA_HOLD_CYC);
      sync_q   <= 1'b0;
      done_s_q <= 1'b0;
      last_q   <= 1'b1;
      cur_q    <= 1'b0;
      grant_q  <= 2'b00;
      dst_q    <= '0;
      scr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= router_done;
      done_s_q <= sync_q;
      last_q   <= last_d;
      cur_q    <= cur_d;
      grant_q  <= grant_d;
      dst_q    <= dst_d;
      scr_q    <= scr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = expired ? cnt_q : cnt_q - 32'd1;
    last_d  = last_q;
    cur_d   = cur_q;
    grant_d = 2'b00;
    dst_d   = dst_q;
    scr_d   = scr_q;
    case (state_q)
      PMA_HOLD: if (expired) begin
        state_d = RST_HOLD;
        cnt_d   = ld(RST_HOLD_CYC);
      end
      RST_HOLD: if (expired) begin
        state_d = SETTLE;
        cnt_d   = ld(SETTLE_CYC);
      end
      SETTLE: if (expired) state_d = IDLE;
      IDLE: if (|req_valid) begin
        state_d = ISSUE;
        cnt_d   = ld(TIMEOUT_CYC);
        cur_d   = sel;
        grant_d = sel ? 2'b10 : 2'b01;
        dst_d   = sel ? req_dst_addr[19:10] : req_dst_addr[9:0];
        scr_d   = sel ? req_scr_addr[19:10] : req_scr_addr[9:0];
      end
      ISSUE:
`ifdef ROUTER_TIMEOUT_EN
        if (done_s_q) state_d = COMPLETE;
        else if (expired) begin
          state_d = PMA_HOLD;
          cnt_d   = ld(PMA_HOLD_CYC);
        end
`else
        if (done_s_q) state_d = COMPLETE;
`endif
      COMPLETE: if (!done_s_q) begin
        state_d = IDLE;
        last_d  = cur_q;
      end
      default: begin
        state_d = PMA_HOLD;
        cnt_d   = ld(PMA_HOLD_CYC);
      end
    endcase
  end
  always_comb begin
    pma_init         = state_q == PMA_HOLD;
    reset_pb         = state_q == PMA_HOLD || state_q == RST_HOLD;
    router_start_req = state_q == ISSUE;
    link_ready       = state_q == IDLE || state_q == ISSUE || state_q == COMPLETE;
    req_grant        = grant_q;
    req_done         = (state_q == COMPLETE && !done_s_q) ? (cur_q ? 2'b10 : 2'b01) : 2'b00;
    router_dst_addr  = dst_q;
    router_scr_addr  = scr_q;
`ifdef ROUTER_TIMEOUT_EN
    timeout_err      = state_q == ISSUE && !done_s_q && expired;
`else
    timeout_err      = 1'b0;
`endif
  end
endmodule

// File: tb/tb_router_bringup_sched.sv
// tb_router_bringup_sched: randomized self-checking bench for router_bringup_sched
module tb_router_bringup_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sys_reset, router_done;
  logic [1:0] req_valid, req_grant, req_done;
  logic [19:0] req_dst_addr, req_scr_addr;
  logic pma_init, reset_pb, router_start_req, link_ready, timeout_err;
  logic [9:0] router_dst_addr, router_scr_addr;
  logic [1:0] z_valid, z_grant, z_done;
  logic [19:0] z_addr;
  logic z_rdone, z_pma, z_rpb, z_start, z_lr, z_tmo;
  logic [9:0] z_dst, z_scr;
  int n_cmp = 0, n_bad = 0;
  int last_g;
  router_bringup_sched #(.TIMEOUT_CYC(50)) dut (
    .init_clk(clk), .sys_reset(sys_reset), .req_valid(req_valid),
    .req_dst_addr(req_dst_addr), .req_scr_addr(req_scr_addr),
    .req_grant(req_grant), .req_done(req_done), .router_done(router_done),
    .pma_init(pma_init), .reset_pb(reset_pb), .router_start_req(router_start_req),
    .router_dst_addr(router_dst_addr), .router_scr_addr(router_scr_addr),
    .link_ready(link_ready), .timeout_err(timeout_err)
  );
  router_bringup_sched #(.PMA_HOLD_CYC(0), .RST_HOLD_CYC(0), .SETTLE_CYC(0), .TIMEOUT_CYC(0)) dut_zero (
    .init_clk(clk), .sys_reset(sys_reset), .req_valid(z_valid),
    .req_dst_addr(z_addr), .req_scr_addr(z_addr),
    .req_grant(z_grant), .req_done(z_done), .router_done(z_rdone),
    .pma_init(z_pma), .reset_pb(z_rpb), .router_start_req(z_start),
    .router_dst_addr(z_dst), .router_scr_addr(z_scr),
    .link_ready(z_lr), .timeout_err(z_tmo)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int winner(input logic [1:0] v, input int last);
    return (v == 2'b11) ? 1 - last : (v == 2'b01 ? 0 : 1);
  endfunction
  // Called right after the edge that put the DUT in PMA_HOLD; walks the whole bring-up.
  task automatic bringup_chk(input bit zero_too);
    chk("reset_state", {pma_init, reset_pb, link_ready, router_start_req, req_grant, req_done, timeout_err}, 9'b110_0_00_00_0);
    if (zero_too) chk("zero_reset", {z_pma, z_rpb, z_lr}, 3'b110);
    last_g = 1;
    for (int n = 1; n <= 1400; n++) begin
      step();
      chk("bringup", {pma_init, reset_pb, link_ready, router_start_req, req_done, timeout_err},
          {n < 150, n < 400, n >= 1400, 1'b0, 2'b00, 1'b0});
      if (zero_too && n <= 4) chk("zero_bringup", {z_pma, z_rpb, z_lr}, {n < 1, n < 2, n >= 3});
    end
  endtask
  task automatic idle_gap(input int k);
    req_valid = 2'b00;
    repeat (k) begin
      step();
      chk("idle_gap", {req_grant, router_start_req, link_ready}, 4'b00_0_1);
    end
  endtask
  // Issued with the DUT in IDLE; router asserts done dly cycles after grant, drops it hold cycles into COMPLETE.
  task automatic do_txn(input logic [1:0] v, input logic [9:0] d0, input logic [9:0] s0,
                        input logic [9:0] d1, input logic [9:0] s1, input int dly, input int hold,
                        output int w);
    logic [19:0] ea;
    w = winner(v, last_g);
    ea = (w == 1) ? {d1, s1} : {d0, s0};
    req_valid = v;
    req_dst_addr = {d1, d0};
    req_scr_addr = {s1, s0};
    step();
    chk("grant", {req_grant, router_start_req}, {(w == 1) ? 2'b10 : 2'b01, 1'b1});
    chk("grant_addr", {router_dst_addr, router_scr_addr}, ea);
    req_valid = 2'($urandom);
    req_dst_addr = 20'($urandom);
    req_scr_addr = 20'($urandom);
    for (int i = 1; i < dly; i++) begin
      step();
      chk("issue_hold", {router_start_req, req_grant, req_done, timeout_err, router_dst_addr, router_scr_addr},
          {1'b1, 2'b00, 2'b00, 1'b0, ea});
    end
    router_done = 1'b1;
    repeat (2) begin
      step();
      chk("sync_delay", router_start_req, 1);
    end
    step();
    chk("complete", {router_start_req, link_ready, req_done}, 4'b0_1_00);
    repeat (hold) begin
      step();
      chk("complete_hold", {router_start_req, req_done}, 3'b0_00);
    end
    router_done = 1'b0;
    step();
    chk("done_sync", req_done, 0);
    step();
    chk("done_pulse", req_done, (w == 1) ? 2'b10 : 2'b01);
    req_valid = 2'b00;
    step();
    chk("back_idle", {req_done, req_grant, router_start_req, link_ready}, 6'b00_00_0_1);
    last_g = w;
  endtask
  initial begin
    int w;
    logic [3:0] order;
    sys_reset = 1'b1;
    router_done = 1'b0;
    req_valid = 2'b00;
    req_dst_addr = '0;
    req_scr_addr = '0;
    z_valid = 2'b00;
    z_addr = '0;
    z_rdone = 1'b0;
    step();
    chk("reset_addr", {router_dst_addr, router_scr_addr}, 0);
    sys_reset = 1'b0;
    bringup_chk(1);
    for (int k = 0; k < 4; k++) begin
      do_txn(2'b11, 10'(16 + k), 10'(32 + k), 10'(48 + k), 10'(64 + k), 3 + k, 1, w);
      order[k] = w[0];
    end
    chk("rr_order", order, 4'b1010);
    do_txn(2'b01, 10'h005, 10'h00A, 10'h3FF, 10'h3FE, 20, 2, w);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 4));
      do_txn(2'($urandom_range(1, 3)), 10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom),
             $urandom_range(1, 30), $urandom_range(0, 3), w);
    end
    req_valid = 2'b10;
    step();
    chk("abort_grant", {req_grant, router_start_req}, 3'b10_1);
    repeat (5) step();
    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0;
    bringup_chk(1);
    do_txn(2'b11, 10'h111, 10'h222, 10'h333, 10'h044, 5, 0, w);
    chk("rr_after_reset", w, 0);
    req_valid = 2'b01;
    step();
    chk("stall_grant", {req_grant, router_start_req}, 3'b01_1);
    req_valid = 2'b00;
`ifdef ROUTER_TIMEOUT_EN
    for (int i = 1; i <= 49; i++) begin
      step();
      chk("timeout", {timeout_err, router_start_req, req_done}, {i == 49, 1'b1, 2'b00});
    end
    step();
    bringup_chk(0);
`else
    for (int i = 1; i <= 10000; i++) begin
      step();
      chk("no_timeout", {timeout_err, router_start_req, req_done}, 4'b0_1_00);
    end
    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0;
    bringup_chk(1);
`endif
    do_txn(2'b10, 10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD, 4, 1, w);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
